// File: rtl/video_timing_generator.sv
// video_timing_generator: free-running raster timing for a progressive display, one pixel per clock.
// Ports:
//   clk_i          pixel clock
//   rst_i          synchronous active-high reset; returns the raster to pixel (0,0)
//   hsync_o        horizontal sync, asserted level HSYNC_POL
//   vsync_o        vertical sync, asserted level VSYNC_POL, whole lines aligned to x=0
//   visible_o      current pixel lies in the active area
//   end_of_line_o  pulse on the last pixel of every line
//   end_of_frame_o pulse on the last pixel of the last line
//   x_o, y_o       position of the pixel currently presented
module video_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW = $clog2(H_TOTAL),
  localparam int YW = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          visible_o,
  output logic          end_of_line_o,
  output logic          end_of_frame_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);
  typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_e;
  // Last position of each phase; the next phase starts on the following pixel/line.
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT_END = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_FP_END = XW'(H_ACTIVE + H_FRONT - 1);
  localparam logic [XW-1:0] X_SYN_END = XW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT_END = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] Y_FP_END = YW'(V_ACTIVE + V_FRONT - 1);
  localparam logic [YW-1:0] Y_SYN_END = YW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  h_state_e h_q, h_d;
  v_state_e v_q, v_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic run_q, eol;
  logic hs_q, vs_q, vis_q, eol_q, eof_q;
  // run_q is low for the first cycle out of reset so that pixel (0,0) is presented, not skipped.
  always_comb begin
    eol = run_q && x_q == X_LAST;
    x_d = (!run_q || eol) ? '0 : x_q + 1'b1;
    y_d = !run_q ? '0 : !eol ? y_q : (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    h_d = (!run_q || eol) ? H_ACT :
          (x_q == X_ACT_END) ? H_FP :
          (x_q == X_FP_END) ? H_SYN :
          (x_q == X_SYN_END) ? H_BP : h_q;
    v_d = !run_q ? V_ACT :
          !eol ? v_q :
          (y_q == Y_LAST) ? V_ACT :
          (y_q == Y_ACT_END) ? V_FP :
          (y_q == Y_FP_END) ? V_SYN :
          (y_q == Y_SYN_END) ? V_BP : v_q;
  end
  // Outputs are decoded from next-state so every output describes the same pixel as x_q/y_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      h_q <= H_ACT;
      v_q <= V_ACT;
      hs_q <= !HSYNC_POL;
      vs_q <= !VSYNC_POL;
      vis_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      x_q <= x_d;
      y_q <= y_d;
      h_q <= h_d;
      v_q <= v_d;
      hs_q <= (h_d == H_SYN) ? HSYNC_POL : !HSYNC_POL;
      vs_q <= (v_d == V_SYN) ? VSYNC_POL : !VSYNC_POL;
      vis_q <= h_d == H_ACT && v_d == V_ACT;
      eol_q <= x_d == X_LAST;
      eof_q <= x_d == X_LAST && y_d == Y_LAST;
    end
  end
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
  assign visible_o = vis_q;
  assign end_of_line_o = eol_q;
  assign end_of_frame_o = eof_q;
  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: checks default 640x480 and a tiny 8x5 raster against a pixel-count model.
module tb_video_timing_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic hs_a, vs_a, vis_a, eol_a, eof_a;
  logic [9:0] x_a, y_a;
  logic hs_b, vs_b, vis_b, eol_b, eof_b;
  logic [2:0] x_b, y_b;
  video_timing_generator dut_a (
    .clk_i(clk), .rst_i(rst_a), .hsync_o(hs_a), .vsync_o(vs_a), .visible_o(vis_a),
    .end_of_line_o(eol_a), .end_of_frame_o(eof_a), .x_o(x_a), .y_o(y_a)
  );
  video_timing_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .hsync_o(hs_b), .vsync_o(vs_b), .visible_o(vis_b),
    .end_of_line_o(eol_b), .end_of_frame_o(eof_b), .x_o(x_b), .y_o(y_b)
  );
  int vec = 0, err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      if (err <= 20) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Pixel n after release is pixel n mod H_TOTAL of line (n div H_TOTAL) mod V_TOTAL.
  function automatic logic [24:0] model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                        input bit hp, vp, r, input int n);
    int ht, vt, x, l;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (r) return {~hp, ~vp, 23'd0};
    x = n % ht;
    l = (n / ht) % vt;
    return {(x >= ha + hf && x < ha + hf + hs) ? hp : ~hp,
            (l >= va + vf && l < va + vf + vs) ? vp : ~vp,
            x < ha && l < va, x == ht - 1, x == ht - 1 && l == vt - 1,
            10'(x), 10'(l)};
  endfunction
  int n_a = 0, n_b = 0;
  bit r_a = 1'b0, r_b = 1'b0, live_a = 1'b0, live_b = 1'b0;
  always @(posedge clk) begin
    if (rst_a) begin r_a <= 1'b1; live_a <= 1'b1; end
    else if (r_a) begin r_a <= 1'b0; n_a <= 0; end
    else n_a <= n_a + 1;
    if (rst_b) begin r_b <= 1'b1; live_b <= 1'b1; end
    else if (r_b) begin r_b <= 1'b0; n_b <= 0; end
    else n_b <= n_b + 1;
  end
  int vcnt, hcnt, ecnt, hstart, last_b;
  always @(negedge clk) begin
    if (live_a) begin
      chk("a_model", {7'd0, hs_a, vs_a, vis_a, eol_a, eof_a, x_a, y_a},
          {7'd0, model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, r_a, n_a)});
      if (r_a) begin
        chk("a_reset", {hs_a, vs_a, vis_a, eol_a, eof_a, x_a, y_a}, {2'b11, 23'd0});
        vcnt = 0; hcnt = 0; ecnt = 0; hstart = -1;
      end else begin
        if (n_a == 0) chk("a_first", {vis_a, x_a, y_a}, {1'b1, 20'd0});
        if (n_a < 800) begin
          vcnt += int'(vis_a);
          ecnt += int'(eol_a);
          if (!hs_a) begin hcnt++; if (hstart < 0) hstart = int'(x_a); end
        end
        if (n_a == 799) chk("a_eol", {eol_a, x_a}, {1'b1, 10'd799});
        if (n_a == 800) begin
          chk("a_vis_run", vcnt, 640);
          chk("a_hs_width", hcnt, 96);
          chk("a_hs_start", hstart, 656);
          chk("a_eol_count", ecnt, 1);
          chk("a_next_line", {x_a, y_a, eol_a}, {10'd0, 10'd1, 1'b0});
        end
      end
    end
    if (live_b) begin
      chk("b_model", {7'd0, hs_b, vs_b, vis_b, eol_b, eof_b, 7'd0, x_b, 7'd0, y_b},
          {7'd0, model(4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1, r_b, n_b)});
      if (r_b) begin
        chk("b_reset", {hs_b, vs_b, vis_b, eof_b}, 4'b0000);
        last_b = -1;
      end else begin
        if (n_b == 0) chk("b_first", {vis_b, x_b, y_b}, {1'b1, 6'd0});
        if (n_b == 4) chk("b_vis_off", {vis_b, hs_b, x_b}, {2'b00, 3'd4});
        if (n_b == 5) chk("b_hs_on", {hs_b, x_b}, {1'b1, 3'd5});
        if (n_b == 7) chk("b_hs_off", {hs_b, x_b}, {1'b0, 3'd7});
        if (n_b == 16) chk("b_line2_blank", {vis_b, y_b}, {1'b0, 3'd2});
        if (n_b == 24) chk("b_vs_on", {vs_b, x_b, y_b}, {1'b1, 3'd0, 3'd3});
        if (n_b == 32) chk("b_vs_off", {vs_b, y_b}, {1'b0, 3'd4});
        if (n_b == 39) chk("b_eof", {eof_b, eol_b, x_b, y_b}, {2'b11, 3'd7, 3'd4});
        if (n_b == 40) chk("b_wrap", {vis_b, eof_b, x_b, y_b}, {2'b10, 6'd0});
        if (eof_b) begin
          if (last_b >= 0) chk("b_eof_period", n_b - last_b, 40);
          last_b = n_b;
        end
      end
    end
  end
  initial begin
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2700) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (150) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (1000) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/video_timing_generator.md
# video_timing_generator

Free-running raster timing generator producing horizontal/vertical sync, the active-video qualifier and line/frame boundary strobes for a progressive display, one pixel per clk_i cycle. Sits directly upstream of the pixel sources (color bar generator, framebuffer scan-out), which consume visible_o, end_of_line_o and x_o/y_o, and drives hsync/vsync to the video DAC/encoder. Default parameters give 640x480@60 (800x525 total).

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync_o (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync_o
- clk_i  in  1  pixel clock; one pixel per cycle
- rst_i  in  1  synchronous, active-high reset
- hsync_o  out  1  horizontal sync, level per HSYNC_POL
- vsync_o  out  1  vertical sync, level per VSYNC_POL
- visible_o  out  1  high while current pixel is in active area
- end_of_line_o  out  1  one-cycle pulse on last pixel (x = H_TOTAL-1) of every line
- end_of_frame_o  out  1  one-cycle pulse on last pixel of last line of frame
- x_o  out  $clog2(H_TOTAL)  current horizontal position
- y_o  out  $clog2(V_TOTAL)  current line

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Counter widths $clog2 of totals; all compares against parameter-derived constants of matching width.
- Horizontal FSM: H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT, each phase lasting its parameter in pixels; x counter 0..H_TOTAL-1, wraps to 0 after H_TOTAL-1.
- Vertical FSM: V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT, advancing only on the last pixel of a line; y counter 0..V_TOTAL-1, wraps to 0 after last pixel of line V_TOTAL-1.
- Phase boundaries (default): hsync asserted for x in 656..751; vsync asserted for y in 490..491 (whole lines, aligned to x=0); visible for x<640 and y<480.
- visible_o = (H state H_ACT) and (V state V_ACT).
- end_of_line_o high when x = H_TOTAL-1, on every line including blanking lines.
- end_of_frame_o high when x = H_TOTAL-1 and y = V_TOTAL-1; coincides with an end_of_line_o pulse.
- Any phase parameter of 0 is illegal; H_ACTIVE and V_ACTIVE must be >=1. No runtime checking required.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Reset (any cycle, including mid-line/mid-frame): on the edge sampling rst_i=1, counters and FSMs go to position (0,0)/H_ACT/V_ACT; outputs go to visible_o=0, end_of_line_o=0, end_of_frame_o=0, x_o=0, y_o=0, hsync_o=!HSYNC_POL, vsync_o=!VSYNC_POL. Held while rst_i high.
- First edge sampling rst_i=0 presents pixel (0,0) on outputs: visible_o=1, x_o=0, y_o=0. Thereafter outputs advance exactly one pixel per cycle; output cycle n after reset release shows pixel n mod H_TOTAL of line (n div H_TOTAL) mod V_TOTAL.
- All outputs for one pixel change on the same edge (sync, visible, strobes, x/y mutually consistent).
- Frame period exactly H_TOTAL*V_TOTAL cycles (420000 default); line period H_TOTAL cycles.

## Test plan
- Reset release: hold rst_i 5 cycles, drop -> during reset hsync_o=vsync_o=1, visible_o=0; first cycle after release visible_o=1, x_o=0, y_o=0; visible_o stays high exactly 640 cycles, then low 160.
- Horizontal sync: line 0 -> hsync_o low for exactly 96 cycles starting at x_o=656; end_of_line_o single pulse at x_o=799, x_o=0 and y_o=1 next cycle.
- Vertical/frame: run one frame -> vsync_o low exactly 1600 cycles starting at y_o=490,x_o=0; visible_o never high for y_o>=480; end_of_frame_o exactly one pulse at (799,524), then (0,0) with visible_o=1; second end_of_frame_o 420000 cycles later.
- Mid-frame reset: assert rst_i at (300,200) for 1 cycle -> next cycle outputs in reset values, following cycle pixel (0,0); subsequent frame period 420000.
- Small parameters H=4/1/2/1, V=2/1/1/1, HSYNC_POL=1 -> H_TOTAL 8, V_TOTAL 5; hsync_o high at x 5..6; vsync_o high on line 3; end_of_frame_o every 40 cycles; visible 4 of 8 pixels on lines 0-1 only.
